// File: rtl/vga_timing_pkg.sv
// Shared video-mode constants and helpers for the raster timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_t;

  // Decoded raster bits, all active-high before polarity is applied.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } timing_bits_t;

  localparam timing_bits_t TimingIdle = '0;

  localparam axis_t Mode640H   = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_t Mode640V   = '{active: 480, fp: 10, sync: 2, bp: 33};
  localparam bit    Mode640Pol = 1'b0;

  localparam axis_t Mode800H   = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_t Mode800V   = '{active: 600, fp: 1, sync: 4, bp: 23};
  localparam bit    Mode800Pol = 1'b1;

  function automatic int unsigned axis_total(input axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Enabled shift register with a reset value; zero depth is a plain wire.
module sync_delay #(
  parameter int unsigned       Depth    = 1,
  parameter int unsigned       Width    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_i, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < Depth; i++) stage_q[i] <= ResetVal;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync/blank/de, line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = Mode640H.active,
  parameter int unsigned H_FP       = Mode640H.fp,
  parameter int unsigned H_SYNC     = Mode640H.sync,
  parameter int unsigned H_BP       = Mode640H.bp,
  parameter int unsigned V_ACTIVE   = Mode640V.active,
  parameter int unsigned V_FP       = Mode640V.fp,
  parameter int unsigned V_SYNC     = Mode640V.sync,
  parameter int unsigned V_BP       = Mode640V.bp,
  parameter bit          HSYNC_POL  = Mode640Pol,
  parameter bit          VSYNC_POL  = Mode640Pol,
  parameter int unsigned PIPE_DELAY = 0,
  parameter int unsigned CW         = 12,
  parameter int unsigned FC_W       = 8
) (
  input  logic            vclock,
  input  logic            reset,
  input  logic            ce,
  output logic [CW-1:0]   hcount,
  output logic [CW-1:0]   vcount,
  output logic            hsync,
  output logic            vsync,
  output logic            blank,
  output logic            de,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam axis_t       HAxis  = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam axis_t       VAxis  = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned HTotal = axis_total(HAxis);
  localparam int unsigned VTotal = axis_total(VAxis);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      CW == 0 || FC_W == 0 || PIPE_DELAY > 15 ||
      64'(HTotal) > (64'd1 << CW) || 64'(VTotal) > (64'd1 << CW)) begin : g_param_check
    $error("vga_timing_gen: invalid timing parameters");
  end

  // Nonzero porches guarantee every threshold is below the total and fits CW bits.
  localparam logic [CW-1:0] HMax      = CW'(HTotal - 1);
  localparam logic [CW-1:0] VMax      = CW'(VTotal - 1);
  localparam logic [CW-1:0] HActEnd   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActEnd   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSyncBeg  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd  = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0]   hcount_q, hcount_d;
  logic [CW-1:0]   vcount_q, vcount_d;
  logic [FC_W-1:0] frame_q, frame_d;
  timing_bits_t    dec_q, dec_d, dly;

  function automatic timing_bits_t decode(input logic [CW-1:0] h, input logic [CW-1:0] v);
    timing_bits_t b;
    b.de = (h < HActEnd) && (v < VActEnd);
    b.hs = (h >= HSyncBeg) && (h < HSyncEnd);
    b.vs = (v >= VSyncBeg) && (v < VSyncEnd);
    b.ls = (h == '0);
    b.fs = (h == '0) && (v == '0);
    return b;
  endfunction

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    if (ce) begin
      if (hcount_q == HMax) begin
        hcount_d = '0;
        if (vcount_q == VMax) begin
          vcount_d = '0;
          frame_d  = frame_q + FC_W'(1);
        end else begin
          vcount_d = vcount_q + CW'(1);
        end
      end else begin
        hcount_d = hcount_q + CW'(1);
      end
    end
  end

  // Decoding the next-state counters keeps the registered bits aligned with hcount/vcount.
  assign dec_d = decode(hcount_d, vcount_d);

  always_ff @(posedge vclock) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      frame_q  <= '0;
      dec_q    <= decode('0, '0);
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_q  <= frame_d;
      dec_q    <= dec_d;
    end
  end

  sync_delay #(
    .Depth   (PIPE_DELAY),
    .Width   ($bits(timing_bits_t)),
    .ResetVal(TimingIdle)
  ) u_delay (
    .clk_i(vclock),
    .rst_i(reset),
    .en_i (ce),
    .d_i  (dec_q),
    .q_o  (dly)
  );

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_count = frame_q;
  assign hsync       = dly.hs ^ ~HSYNC_POL;
  assign vsync       = dly.vs ^ ~VSYNC_POL;
  assign de          = dly.de;
  assign blank       = ~dly.de;
  // Gating with ce keeps each strobe one vclock wide when ce is sparse.
  assign line_start  = dly.ls & ce;
  assign frame_start = dly.fs & ce;

endmodule
